// File: rtl/ks_add_pkg.sv
// Shared definitions for the Kogge-Stone adder arbiter: datapath width,
// arbiter state encoding and the signed-overflow rule.
package ks_add_pkg;

   localparam int ADD_W = 32;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Two's-complement overflow: operands agree in sign, sum disagrees.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/ks_add32.sv
// 32-bit Kogge-Stone prefix adder. Level 0 forms bit generate/propagate
// (carry-in folded into bit 0), then log2(32) prefix levels combine
// (g,p) pairs at doubling distance; bits below the distance pass through.
module ks_add32
   import ks_add_pkg::*;
(
   input  logic [ADD_W-1:0] a,
   input  logic [ADD_W-1:0] b,
   input  logic             cin,
   output logic [ADD_W-1:0] sum,
   output logic             cout
);

   localparam int LEVELS = $clog2(ADD_W);

   logic [ADD_W-1:0] g_cur;
   logic [ADD_W-1:0] p_cur;
   logic [ADD_W-1:0] g_nxt;
   logic [ADD_W-1:0] p_nxt;
   logic [ADD_W-1:0] carry;

   // Prefix tree: after the last level g_cur[i] is the carry out of bit i.
   always_comb begin
      g_cur    = a & b;
      p_cur    = a ^ b;
      g_cur[0] = g_cur[0] | (p_cur[0] & cin);
      g_nxt    = g_cur;
      p_nxt    = p_cur;
      for (int lv = 0; lv < LEVELS; lv++) begin
         g_nxt = g_cur;
         p_nxt = p_cur;
         for (int i = (1 << lv); i < ADD_W; i++) begin
            g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-(1<<lv)]);
            p_nxt[i] = p_cur[i] & p_cur[i-(1<<lv)];
         end
         g_cur = g_nxt;
         p_cur = p_nxt;
      end
      carry = {g_cur[ADD_W-2:0], cin};
      sum   = (a ^ b) ^ carry;
      cout  = g_cur[ADD_W-1];
   end

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping
// modulo N_REQ. Returns a one-hot grant and its index (0 when none).
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx
);

   logic found;

   // Scan by distance from ptr; all indices are constants so no
   // variable bit-selects are needed for non-power-of-two N_REQ.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && valid[i] &&
                (((i - int'(ptr) + N_REQ) % N_REQ) == k)) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               idx      = ID_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/ks_add_arbiter.sv
// Shares one Kogge-Stone adder among N_REQ requesters. Round-robin
// between operations; a multi-beat operation holds the grant until its
// last beat and chains the carry between beats. One registered result.
module ks_add_arbiter
   import ks_add_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*ADD_W-1:0] req_a,
   input  logic [N_REQ*ADD_W-1:0] req_b,
   input  logic [N_REQ-1:0]       req_cin,
   input  logic [N_REQ-1:0]       req_last,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [ADD_W-1:0]       res_sum,
   output logic                   res_cout,
   output logic                   res_ovf,
   output logic [ID_W-1:0]        res_id,
   output logic                   res_last
);

   arb_state_e       state_q,     state_d;
   logic [ID_W-1:0]  owner_q,     owner_d;
   logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
   logic             chain_c_q,   chain_c_d;
   logic             res_valid_q, res_valid_d;
   logic [ADD_W-1:0] res_sum_q,   res_sum_d;
   logic             res_cout_q,  res_cout_d;
   logic             res_ovf_q,   res_ovf_d;
   logic [ID_W-1:0]  res_id_q,    res_id_d;
   logic             res_last_q,  res_last_d;

   logic [N_REQ-1:0] pick_grant;
   logic [ID_W-1:0]  pick_idx;
   logic [ID_W-1:0]  sel_idx;
   logic             can_load;
   logic             accept;
   logic [ADD_W-1:0] add_a;
   logic [ADD_W-1:0] add_b;
   logic             add_cin;
   logic             sel_last;
   logic [ADD_W-1:0] add_sum;
   logic             add_cout;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   ks_add32 u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Grant selection and operand muxing; only the owner is eligible in BURST.
   always_comb begin
      can_load  = !res_valid_q || res_ready;
      sel_idx   = (state_q == BURST) ? owner_q : pick_idx;
      req_ready = '0;
      if (can_load) begin
         if (state_q == BURST) begin
            for (int i = 0; i < N_REQ; i++) begin
               if (owner_q == ID_W'(i)) req_ready[i] = 1'b1;
            end
         end else begin
            req_ready = pick_grant;
         end
      end
      accept   = |(req_valid & req_ready);
      add_a    = '0;
      add_b    = '0;
      add_cin  = 1'b0;
      sel_last = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_idx == ID_W'(i)) begin
            add_a    = req_a[i*ADD_W +: ADD_W];
            add_b    = req_b[i*ADD_W +: ADD_W];
            add_cin  = req_cin[i];
            sel_last = req_last[i];
         end
      end
      if (state_q == BURST) add_cin = chain_c_q;
   end

   // Next-state: result register load/drain, burst lock and pointer advance.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      chain_c_d   = chain_c_q;
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
      res_cout_d  = res_cout_q;
      res_ovf_d   = res_ovf_q;
      res_id_d    = res_id_q;
      res_last_d  = res_last_q;
      if (accept) begin
         res_valid_d = 1'b1;
         res_sum_d   = add_sum;
         res_cout_d  = add_cout;
         res_ovf_d   = signed_ovf(add_a[ADD_W-1], add_b[ADD_W-1], add_sum[ADD_W-1]);
         res_id_d    = sel_idx;
         res_last_d  = sel_last;
         chain_c_d   = add_cout;
         if (sel_last) begin
            state_d  = ARB;
            rr_ptr_d = (sel_idx == ID_W'(N_REQ-1)) ? '0 : sel_idx + ID_W'(1);
         end else begin
            state_d = BURST;
            owner_d = sel_idx;
         end
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   // State and result registers; reset clears everything including a burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         chain_c_q   <= 1'b0;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_cout_q  <= 1'b0;
         res_ovf_q   <= 1'b0;
         res_id_q    <= '0;
         res_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         chain_c_q   <= chain_c_d;
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
         res_cout_q  <= res_cout_d;
         res_ovf_q   <= res_ovf_d;
         res_id_q    <= res_id_d;
         res_last_q  <= res_last_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_sum   = res_sum_q;
   assign res_cout  = res_cout_q;
   assign res_ovf   = res_ovf_q;
   assign res_id    = res_id_q;
   assign res_last  = res_last_q;

endmodule

// File: tb/tb_ks_add_arbiter.sv
// Directed bench for ks_add_arbiter with four requesters.
module tb_ks_add_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [3:0]   req_cin;
   logic [3:0]   req_last;
   logic         res_valid;
   logic         res_ready;
   logic [31:0]  res_sum;
   logic         res_cout;
   logic         res_ovf;
   logic [1:0]   res_id;
   logic         res_last;

   int errors = 0;
   int checks = 0;

   ks_add_arbiter #(.N_REQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_last  (req_last),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_ovf   (res_ovf),
      .res_id    (res_id),
      .res_last  (res_last)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic last, input logic v);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_cin[i]        = cin;
      req_last[i]       = last;
      req_valid[i]      = v;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      res_ready = 1'b1;
      set_req(0, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1);
      tick();
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
      checks++; if (res_sum !== 32'h0) begin errors++; $display("FAIL reset_sum got=%h exp=00000000", res_sum); end
      checks++; if ({res_cout, res_ovf, res_last} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {res_cout, res_ovf, res_last}); end
      checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", res_id); end
      req_valid[0] = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
   endtask

   task automatic test_single;
      set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
      tick();
      req_valid[0] = 1'b0;
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", res_valid); end
      checks++; if (res_sum !== 32'h0) begin errors++; $display("FAIL single_sum got=%h exp=00000000", res_sum); end
      checks++; if ({res_cout, res_ovf} !== 2'b10) begin errors++; $display("FAIL single_cout_ovf got=%b exp=10", {res_cout, res_ovf}); end
      checks++; if ({res_id, res_last} !== 3'b001) begin errors++; $display("FAIL single_id_last got=%b exp=001", {res_id, res_last}); end
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", res_valid); end
   endtask

   // Pointer is 1 after the single op, so req1 is picked.
   task automatic test_overflow;
      set_req(1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ovf_ready got=%b exp=0010", req_ready); end
      tick();
      req_valid[1] = 1'b0;
      checks++; if (res_sum !== 32'h8000_0000) begin errors++; $display("FAIL ovf_sum got=%h exp=80000000", res_sum); end
      checks++; if ({res_cout, res_ovf} !== 2'b01) begin errors++; $display("FAIL ovf_flags got=%b exp=01", {res_cout, res_ovf}); end
      checks++; if (res_id !== 2'd1) begin errors++; $display("FAIL ovf_id got=%0d exp=1", res_id); end
      tick();
   endtask

   task automatic test_round_robin;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 32'(i * 16), 32'h1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (res_valid !== 1'b1 || res_id !== 2'(k % 4) || res_sum !== 32'((k % 4) * 16 + 1)) begin
            errors++;
            $display("FAIL rr_beat%0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h",
                     k, res_valid, res_id, res_sum, k % 4, (k % 4) * 16 + 1);
         end
      end
      req_valid = 4'b0000;
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got=%b exp=0", res_valid); end
   endtask

   // Pointer is 1 here; a req1 single op moves it to 2 so req2 leads the chain.
   task automatic test_chain;
      set_req(1, 32'h5, 32'h6, 1'b0, 1'b1, 1'b1);
      tick();
      req_valid[1] = 1'b0;
      checks++; if (res_sum !== 32'hB || res_id !== 2'd1) begin errors++; $display("FAIL chain_pre got sum=%h id=%0d exp sum=0000000b id=1", res_sum, res_id); end
      set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
      set_req(1, 32'h3, 32'h4, 1'b0, 1'b1, 1'b1);
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL chain_ready0 got=%b exp=0100", req_ready); end
      tick();
      checks++; if (res_sum !== 32'h0 || res_cout !== 1'b1 || res_id !== 2'd2 || res_last !== 1'b0) begin
         errors++; $display("FAIL chain_beat0 got sum=%h c=%b id=%0d last=%b exp sum=00000000 c=1 id=2 last=0", res_sum, res_cout, res_id, res_last); end
      req_valid[2] = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL chain_lock got=%b exp=0100", req_ready); end
      tick();
      checks++; if (res_valid !== 1'b0 || req_ready !== 4'b0100) begin errors++; $display("FAIL chain_stall got v=%b rdy=%b exp v=0 rdy=0100", res_valid, req_ready); end
      set_req(2, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
      tick();
      req_valid[2] = 1'b0;
      checks++; if (res_sum !== 32'h1 || res_cout !== 1'b0 || res_id !== 2'd2 || res_last !== 1'b1) begin
         errors++; $display("FAIL chain_beat1 got sum=%h c=%b id=%0d last=%b exp sum=00000001 c=0 id=2 last=1", res_sum, res_cout, res_id, res_last); end
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL chain_after_ready got=%b exp=0010", req_ready); end
      tick();
      req_valid[1] = 1'b0;
      checks++; if (res_sum !== 32'h7 || res_id !== 2'd1) begin errors++; $display("FAIL chain_req1 got sum=%h id=%0d exp sum=00000007 id=1", res_sum, res_id); end
      tick();
   endtask

   // Pointer is 2: req3 goes first, then req0 waits behind backpressure.
   task automatic test_backpressure;
      set_req(3, 32'h10, 32'h20, 1'b0, 1'b1, 1'b1);
      set_req(0, 32'h100, 32'h1, 1'b0, 1'b1, 1'b1);
      tick();
      req_valid[3] = 1'b0;
      res_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready got=%b exp=0000", req_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (res_valid !== 1'b1 || res_sum !== 32'h30 || res_id !== 2'd3 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b sum=%h id=%0d rdy=%b exp v=1 sum=00000030 id=3 rdy=0000",
                     k, res_valid, res_sum, res_id, req_ready);
         end
      end
      res_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready got=%b exp=0001", req_ready); end
      tick();
      req_valid[0] = 1'b0;
      checks++; if (res_valid !== 1'b1 || res_sum !== 32'h101 || res_id !== 2'd0) begin
         errors++; $display("FAIL bp_reload got v=%b sum=%h id=%0d exp v=1 sum=00000101 id=0", res_valid, res_sum, res_id); end
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", res_valid); end
   endtask

   // Pointer is 1; abandon a req2 burst with reset, then pointer order restarts at 0.
   task automatic test_reset_mid_burst;
      set_req(2, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1);
      tick();
      req_valid[2] = 1'b0;
      checks++; if (res_valid !== 1'b1 || res_sum !== 32'h3) begin errors++; $display("FAIL rmb_beat0 got v=%b sum=%h exp v=1 sum=00000003", res_valid, res_sum); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (res_valid !== 1'b0 || res_sum !== 32'h0) begin errors++; $display("FAIL rmb_cleared got v=%b sum=%h exp v=0 sum=00000000", res_valid, res_sum); end
      set_req(0, 32'h40, 32'h2, 1'b0, 1'b1, 1'b1);
      set_req(3, 32'h50, 32'h3, 1'b0, 1'b1, 1'b1);
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmb_ready got=%b exp=0001", req_ready); end
      tick();
      req_valid[0] = 1'b0;
      checks++; if (res_sum !== 32'h42 || res_id !== 2'd0) begin errors++; $display("FAIL rmb_first got sum=%h id=%0d exp sum=00000042 id=0", res_sum, res_id); end
      tick();
      req_valid[3] = 1'b0;
      checks++; if (res_sum !== 32'h53 || res_id !== 2'd3) begin errors++; $display("FAIL rmb_second got sum=%h id=%0d exp sum=00000053 id=3", res_sum, res_id); end
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      res_ready = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      req_last  = '0;
      test_reset();
      test_single();
      test_overflow();
      test_round_robin();
      test_chain();
      test_backpressure();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
